// File: rtl/exu_wbck_arb_pkg.sv
// Shared widths, OITF geometry and writeback types for the execute-stage writeback scheduler.
package exu_wbck_arb_pkg;

    localparam int XLEN        = 32;
    localparam int RFIDX_WIDTH = 5;
    localparam int OITF_DEPTH  = 2;
    localparam int OITF_IDX_W  = $clog2(OITF_DEPTH);
    localparam int OITF_PTR_W  = OITF_IDX_W + 1;

    typedef logic [XLEN-1:0]        data_t;
    typedef logic [RFIDX_WIDTH-1:0] rfidx_t;
    typedef logic [OITF_PTR_W-1:0]  oitf_ptr_t;
    typedef logic [OITF_IDX_W-1:0]  oitf_idx_t;

    typedef struct packed {
        data_t  wdat;
        rfidx_t rdidx;
    } wbck_t;

    // x0 is never a real destination, so it can never create a hazard.
    function automatic logic idx_hit(rfidx_t entry, rfidx_t idx);
        return (entry != '0) && (entry == idx);
    endfunction

endpackage

// File: rtl/exu_wbck_arb_if.sv
// Dispatch, writeback-source and register-file signals of the writeback scheduler.
interface exu_wbck_arb_if;
    import exu_wbck_arb_pkg::*;

    logic   ld_disp_valid;
    logic   ld_disp_ready;
    rfidx_t ld_disp_rdidx;
    rfidx_t disp_rs1idx;
    rfidx_t disp_rs2idx;
    rfidx_t disp_rdidx;
    logic   oitf_dep;
    logic   oitf_empty;

    logic   alu_wbck_i_valid;
    logic   alu_wbck_i_ready;
    data_t  alu_wbck_i_wdat;
    rfidx_t alu_wbck_i_rdidx;

    logic   lsu_wbck_i_valid;
    logic   lsu_wbck_i_ready;
    data_t  lsu_wbck_i_wdat;

    logic   rf_wbck_o_ena;
    data_t  rf_wbck_o_wdat;
    rfidx_t rf_wbck_o_rdidx;

    modport master (
        output ld_disp_valid, ld_disp_rdidx, disp_rs1idx, disp_rs2idx, disp_rdidx,
        output alu_wbck_i_valid, alu_wbck_i_wdat, alu_wbck_i_rdidx,
        output lsu_wbck_i_valid, lsu_wbck_i_wdat,
        input  ld_disp_ready, oitf_dep, oitf_empty,
        input  alu_wbck_i_ready, lsu_wbck_i_ready,
        input  rf_wbck_o_ena, rf_wbck_o_wdat, rf_wbck_o_rdidx
    );

    modport slave (
        input  ld_disp_valid, ld_disp_rdidx, disp_rs1idx, disp_rs2idx, disp_rdidx,
        input  alu_wbck_i_valid, alu_wbck_i_wdat, alu_wbck_i_rdidx,
        input  lsu_wbck_i_valid, lsu_wbck_i_wdat,
        output ld_disp_ready, oitf_dep, oitf_empty,
        output alu_wbck_i_ready, lsu_wbck_i_ready,
        output rf_wbck_o_ena, rf_wbck_o_wdat, rf_wbck_o_rdidx
    );

endinterface

// File: rtl/exu_wbck_arb_oitf.sv
// Outstanding-load FIFO: circular buffer of load destinations with wrap-bit pointers
// and a combinational hazard compare against the instruction being dispatched.
module exu_oitf
    import exu_wbck_arb_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   alc_vld_i,
    input  rfidx_t alc_rdidx_i,
    input  logic   ret_vld_i,
    input  rfidx_t rs1idx_i,
    input  rfidx_t rs2idx_i,
    input  rfidx_t rdidx_i,
    output rfidx_t ret_rdidx_o,
    output logic   full_o,
    output logic   empty_o,
    output logic   dep_o
);

    rfidx_t    mem_q [OITF_DEPTH];
    oitf_ptr_t wr_ptr_q, wr_ptr_d;
    oitf_ptr_t rd_ptr_q, rd_ptr_d;
    oitf_ptr_t count;
    oitf_idx_t wr_idx, rd_idx;
    oitf_idx_t offs [OITF_DEPTH];

    assign wr_idx      = wr_ptr_q[OITF_IDX_W-1:0];
    assign rd_idx      = rd_ptr_q[OITF_IDX_W-1:0];
    assign empty_o     = (wr_ptr_q == rd_ptr_q);
    assign full_o      = (wr_idx == rd_idx) && (wr_ptr_q[OITF_IDX_W] != rd_ptr_q[OITF_IDX_W]);
    assign count       = wr_ptr_q - rd_ptr_q;
    assign ret_rdidx_o = mem_q[rd_idx];
    assign wr_ptr_d    = wr_ptr_q + oitf_ptr_t'(alc_vld_i);
    assign rd_ptr_d    = rd_ptr_q + oitf_ptr_t'(ret_vld_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: the entry storage has no reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (alc_vld_i) begin
            mem_q[wr_idx] <= alc_rdidx_i;
        end
    end

    // An entry is live when its distance from the head is below the occupancy.
    always_comb begin
        dep_o = 1'b0;
        for (int i = 0; i < OITF_DEPTH; i++) begin
            offs[i] = oitf_idx_t'(i) - rd_idx;
            if (({1'b0, offs[i]} < count) &&
                (idx_hit(mem_q[i], rs1idx_i) || idx_hit(mem_q[i], rs2idx_i) ||
                 idx_hit(mem_q[i], rdidx_i))) begin
                dep_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/exu_wbck_arb.sv
// Writeback scheduler: shares the register-file write port between load responses
// (priority) and ALU commits, and registers the granted write.
module exu_wbck_arb
    import exu_wbck_arb_pkg::*;
(
    input logic           clk,
    input logic           rst,
    exu_wbck_arb_if.slave bus
);

    logic   oitf_full, oitf_empty_w;
    logic   ld_hs, lsu_hs, alu_hs;
    rfidx_t lsu_rdidx;
    wbck_t  wbck_q, wbck_d;
    logic   ena_q, ena_d;

    // Readies come from current state only, so a blocked allocate stays blocked on a retire cycle.
    assign ld_hs                = bus.ld_disp_valid & ~oitf_full;
    assign lsu_hs               = bus.lsu_wbck_i_valid & ~oitf_empty_w;
    assign alu_hs               = bus.alu_wbck_i_valid & ~lsu_hs;
    assign bus.ld_disp_ready    = ~oitf_full;
    assign bus.lsu_wbck_i_ready = ~oitf_empty_w;
    assign bus.alu_wbck_i_ready = ~lsu_hs;
    assign bus.oitf_empty       = oitf_empty_w;

    exu_oitf u_oitf (
        .clk         (clk),
        .rst         (rst),
        .alc_vld_i   (ld_hs),
        .alc_rdidx_i (bus.ld_disp_rdidx),
        .ret_vld_i   (lsu_hs),
        .rs1idx_i    (bus.disp_rs1idx),
        .rs2idx_i    (bus.disp_rs2idx),
        .rdidx_i     (bus.disp_rdidx),
        .ret_rdidx_o (lsu_rdidx),
        .full_o      (oitf_full),
        .empty_o     (oitf_empty_w),
        .dep_o       (bus.oitf_dep)
    );

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        wbck_d = wbck_q;
        if (lsu_hs) begin
            wbck_d = '{wdat: bus.lsu_wbck_i_wdat, rdidx: lsu_rdidx};
        end else if (alu_hs) begin
            wbck_d = '{wdat: bus.alu_wbck_i_wdat, rdidx: bus.alu_wbck_i_rdidx};
        end
        ena_d = (lsu_hs | alu_hs) & (wbck_d.rdidx != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ena_q  <= 1'b0;
            wbck_q <= '0;
        end else begin
            ena_q  <= ena_d;
            wbck_q <= wbck_d;
        end
    end

    assign bus.rf_wbck_o_ena   = ena_q;
    assign bus.rf_wbck_o_wdat  = wbck_q.wdat;
    assign bus.rf_wbck_o_rdidx = wbck_q.rdidx;

endmodule

// File: tb/tb_exu_wbck_arb.sv
// Self-checking bench: a queue-based model of outstanding loads checked every cycle,
// plus directed scenarios with literal expectations.
module tb_exu_wbck_arb;
    import exu_wbck_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exu_wbck_arb_if bus ();

    exu_wbck_arb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int     n_tests = 0;
    int     n_fail  = 0;
    rfidx_t oq [$];
    logic   exp_ena   = 1'b0;
    data_t  exp_wdat  = '0;
    rfidx_t exp_rdidx = '0;
    bit     model_on  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: loads queue in dispatch order, responses pop the head, LSU beats ALU.
    function automatic void model_step();
        bit lsu_acc, alu_acc, ld_acc;
        if (rst) begin
            oq.delete();
            exp_ena   = 1'b0;
            exp_wdat  = '0;
            exp_rdidx = '0;
            model_on  = 1'b1;
        end else begin
            lsu_acc = bus.lsu_wbck_i_valid && (oq.size() != 0);
            alu_acc = bus.alu_wbck_i_valid && !lsu_acc;
            ld_acc  = bus.ld_disp_valid && (oq.size() < OITF_DEPTH);
            if (lsu_acc) begin
                exp_rdidx = oq[0];
                exp_wdat  = bus.lsu_wbck_i_wdat;
                exp_ena   = (oq[0] != 0);
                void'(oq.pop_front());
            end else if (alu_acc) begin
                exp_rdidx = bus.alu_wbck_i_rdidx;
                exp_wdat  = bus.alu_wbck_i_wdat;
                exp_ena   = (bus.alu_wbck_i_rdidx != 0);
            end else begin
                exp_ena = 1'b0;
            end
            if (ld_acc) oq.push_back(bus.ld_disp_rdidx);
        end
    endfunction

    task automatic compare_all();
        int sz;
        bit dep;
        sz  = oq.size();
        dep = 1'b0;
        foreach (oq[i]) begin
            if (oq[i] != 0 && (oq[i] == bus.disp_rs1idx || oq[i] == bus.disp_rs2idx ||
                               oq[i] == bus.disp_rdidx))
                dep = 1'b1;
        end
        check("oitf_empty", bus.oitf_empty, sz == 0);
        check("ld_disp_ready", bus.ld_disp_ready, sz < OITF_DEPTH);
        check("lsu_ready", bus.lsu_wbck_i_ready, sz != 0);
        check("alu_ready", bus.alu_wbck_i_ready, !(bus.lsu_wbck_i_valid && sz != 0));
        check("oitf_dep", bus.oitf_dep, dep);
        check("rf_ena", bus.rf_wbck_o_ena, exp_ena);
        if (exp_ena) begin
            check("rf_wdat", bus.rf_wbck_o_wdat, exp_wdat);
            check("rf_rdidx", bus.rf_wbck_o_rdidx, exp_rdidx);
        end
    endtask

    always @(posedge clk) model_step();
    always @(negedge clk) if (model_on) compare_all();

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.ld_disp_valid    = 1'b0;
        bus.alu_wbck_i_valid = 1'b0;
        bus.lsu_wbck_i_valid = 1'b0;
    endtask

    task automatic load(input rfidx_t rd);
        bus.ld_disp_valid = 1'b1;
        bus.ld_disp_rdidx = rd;
    endtask

    task automatic alu(input rfidx_t rd, input data_t d);
        bus.alu_wbck_i_valid = 1'b1;
        bus.alu_wbck_i_rdidx = rd;
        bus.alu_wbck_i_wdat  = d;
    endtask

    task automatic lsu(input data_t d);
        bus.lsu_wbck_i_valid = 1'b1;
        bus.lsu_wbck_i_wdat  = d;
    endtask

    task automatic srcs(input rfidx_t r1, input rfidx_t r2, input rfidx_t rd);
        bus.disp_rs1idx = r1;
        bus.disp_rs2idx = r2;
        bus.disp_rdidx  = rd;
    endtask

    task automatic expect_wr(input string name, input rfidx_t rd, input data_t d);
        check({name, "_ena"}, bus.rf_wbck_o_ena, 1'b1);
        check({name, "_rdidx"}, bus.rf_wbck_o_rdidx, rd);
        check({name, "_wdat"}, bus.rf_wbck_o_wdat, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        bus.ld_disp_rdidx    = '0;
        bus.alu_wbck_i_rdidx = '0;
        bus.alu_wbck_i_wdat  = '0;
        bus.lsu_wbck_i_wdat  = '0;
        srcs(0, 0, 0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        mid();
        check("rst_ena", bus.rf_wbck_o_ena, 1'b0);
        check("rst_wdat", bus.rf_wbck_o_wdat, 0);
        check("rst_rdidx", bus.rf_wbck_o_rdidx, 0);
        check("rst_empty", bus.oitf_empty, 1'b1);
        check("rst_ld_ready", bus.ld_disp_ready, 1'b1);
        check("rst_dep", bus.oitf_dep, 1'b0);

        // Single ALU write.
        tick(); alu(5, 32'hDEADBEEF);
        mid();  check("t1_alu_ready", bus.alu_wbck_i_ready, 1'b1);
        tick(); idle();
        mid();  expect_wr("t1", 5, 32'hDEADBEEF);

        // Load round-trip.
        tick(); load(7);
        tick(); idle(); srcs(7, 0, 0);
        mid();  check("t2_dep", bus.oitf_dep, 1'b1);
                check("t2_empty", bus.oitf_empty, 1'b0);
        tick(); lsu(32'h1234);
        tick(); idle();
        mid();  expect_wr("t2", 7, 32'h1234);
                check("t2_empty_after", bus.oitf_empty, 1'b1);
                check("t2_dep_after", bus.oitf_dep, 1'b0);
        srcs(0, 0, 0);

        // Collision: LSU wins, ALU follows.
        tick(); load(9);
        tick(); idle(); alu(3, 32'hAAAA0003); lsu(32'hBBBB0009);
        mid();  check("t3_alu_ready", bus.alu_wbck_i_ready, 1'b0);
                check("t3_lsu_ready", bus.lsu_wbck_i_ready, 1'b1);
        tick(); bus.lsu_wbck_i_valid = 1'b0;
        mid();  expect_wr("t3_lsu", 9, 32'hBBBB0009);
                check("t3_alu_ready2", bus.alu_wbck_i_ready, 1'b1);
        tick(); idle();
        mid();  expect_wr("t3_alu", 3, 32'hAAAA0003);

        // Full OITF: third dispatch held through a retire cycle.
        tick(); load(1);
        tick(); load(2);
        tick(); load(3);
        mid();  check("t4_full_ready", bus.ld_disp_ready, 1'b0);
        tick(); lsu(32'h11);
        mid();  check("t4_ready_on_retire", bus.ld_disp_ready, 1'b0);
        tick(); bus.lsu_wbck_i_valid = 1'b0;
        mid();  expect_wr("t4_x1", 1, 32'h11);
                check("t4_ready_after", bus.ld_disp_ready, 1'b1);
        tick(); idle(); lsu(32'h22);
        mid();  check("t4_model_occ", oq.size(), 2);
        tick(); lsu(32'h33);
        mid();  expect_wr("t4_x2", 2, 32'h22);
        tick(); idle();
        mid();  expect_wr("t4_x3", 3, 32'h33);
                check("t4_empty", bus.oitf_empty, 1'b1);

        // x0 load and protocol violation.
        tick(); load(0);
        tick(); idle(); srcs(0, 0, 0);
        mid();  check("t5_dep_x0", bus.oitf_dep, 1'b0);
                check("t5_empty", bus.oitf_empty, 1'b0);
        tick(); lsu(32'h55);
        tick(); idle();
        mid();  check("t5_ena_x0", bus.rf_wbck_o_ena, 1'b0);
                check("t5_retired", bus.oitf_empty, 1'b1);
        tick(); lsu(32'h66);
        mid();  check("t5_lsu_ready_empty", bus.lsu_wbck_i_ready, 1'b0);
                check("t5_alu_ready_empty", bus.alu_wbck_i_ready, 1'b1);
        tick(); idle();
        mid();  check("t5_no_write", bus.rf_wbck_o_ena, 1'b0);

        // Reset mid-operation with an ALU write in the reset cycle.
        tick(); load(4);
        tick(); load(6);
        tick(); idle(); srcs(4, 6, 0);
        mid();  check("t6_full", bus.ld_disp_ready, 1'b0);
                check("t6_dep", bus.oitf_dep, 1'b1);
        tick(); rst = 1'b1; alu(8, 32'h88);
        tick(); rst = 1'b0; idle();
        mid();  check("t6_empty", bus.oitf_empty, 1'b1);
                check("t6_ena", bus.rf_wbck_o_ena, 1'b0);
                check("t6_dep_cleared", bus.oitf_dep, 1'b0);
                check("t6_model_occ", oq.size(), 0);
        tick(); lsu(32'h77);
        mid();  check("t6_stale_refused", bus.lsu_wbck_i_ready, 1'b0);
        tick(); idle();
        mid();  check("t6_no_write", bus.rf_wbck_o_ena, 1'b0);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/exu_wbck_arb.md
# exu_wbck_arb

Writeback scheduler for the execute stage. It shares the single register-file write port between the ALU commit path and the LSU load-response path, giving LSU responses priority. It tracks outstanding loads in an in-order issue FIFO (OITF) that supplies the destination index for each load response. The OITF also provides RAW/WAW dependency flags so the dispatcher can stall instructions that read or write a register a load has not yet written.

## Interface
- `XLEN`, 32: data width.
- `RFIDX_WIDTH`, 5: register index width.
- `OITF_DEPTH`, 2: maximum outstanding loads; power of two, ≥2.

Ports (name, direction, width, meaning):
- `clk` in 1: clock.
- `rst` in 1: synchronous reset, active-high.
- `ld_disp_valid` in 1: a load is dispatched to the LSU.
- `ld_disp_ready` out 1: the OITF can accept a load.
- `ld_disp_rdidx` in RFIDX_WIDTH: load destination register.
- `disp_rs1idx`, `disp_rs2idx`, `disp_rdidx` in RFIDX_WIDTH each: indices of the instruction being dispatched.
- `oitf_dep` out 1: a pending load targets rs1, rs2 or rd.
- `oitf_empty` out 1: no load is outstanding.
- `alu_wbck_i_valid` in 1, `alu_wbck_i_ready` out 1: ALU writeback handshake.
- `alu_wbck_i_wdat` in XLEN, `alu_wbck_i_rdidx` in RFIDX_WIDTH: ALU writeback data and destination.
- `lsu_wbck_i_valid` in 1, `lsu_wbck_i_ready` out 1: load response handshake.
- `lsu_wbck_i_wdat` in XLEN: load data.
- `rf_wbck_o_ena` out 1: register-file write enable (registered).
- `rf_wbck_o_wdat` out XLEN: write data (registered).
- `rf_wbck_o_rdidx` out RFIDX_WIDTH: write index (registered).

## Operation
- **OITF storage:** circular buffer of OITF_DEPTH rdidx entries.
- **Pointers:** read and write pointers, each log2(OITF_DEPTH)+1 bits including a wrap bit.
  - empty = pointers equal.
  - full = index bits equal and wrap bits differ.
- **Allocate:** on `ld_disp_valid & ld_disp_ready`, with `ld_disp_ready = !full`. Write `ld_disp_rdidx` at the write pointer, then increment it.
- **Retire:** on `lsu_wbck_i_valid & lsu_wbck_i_ready`, with `lsu_wbck_i_ready = !empty`. Increment the read pointer.
  - LSU responses arrive in dispatch order.
  - The response's destination is the entry at the head (read pointer).
- **Allocate and retire in the same cycle:** both take effect, so occupancy is unchanged.
  - When full, allocation is blocked even if a retire occurs that cycle, because `ld_disp_ready` is computed from the current state.
  - When empty, a retire is impossible.
- **Dependency check:** `oitf_dep` = OR over valid entries of (entry == rs1 | entry == rs2 | entry == rd).
  - Index 0 never matches.
  - Combinational.
- **Arbitration:** LSU has priority.
  - `alu_wbck_i_ready = !(lsu_wbck_i_valid & !empty)`.
  - Grant is selected from LSU first, then ALU.
- **Write port:** the granted write is registered.
  - `rf_wbck_o_ena` = granted, and rdidx != 0.
  - A write to x0 is still accepted and still retires its OITF entry, but `ena` stays 0.
- **Protocol violation:** `lsu_wbck_i_valid` while the OITF is empty is not accepted (ready = 0) and has no effect.

## Timing
- **Reset values:** `rf_wbck_o_ena` = 0, `rf_wbck_o_wdat` = 0, `rf_wbck_o_rdidx` = 0, pointers = 0.
  - After reset: `oitf_empty` = 1, `ld_disp_ready` = 1, `oitf_dep` = 0.
- **Reset mid-operation:** all outstanding entries are discarded.
  - Late LSU responses are refused because the OITF is empty.
  - A write registered in the reset cycle is dropped (`ena` = 0 on the next cycle).
- **Write latency:** a handshake accepted in cycle N produces the register-file write in cycle N+1.
- **Throughput:** one write per cycle. The register file never back-pressures.
- **Combinational outputs:** `ld_disp_ready`, `lsu_wbck_i_ready`, `alu_wbck_i_ready`, `oitf_dep`, `oitf_empty` depend only on current state and inputs.
  - No valid depends on a ready.
- **Dependency visibility:**
  - An entry allocated in cycle N is visible to `oitf_dep` in cycle N+1.
  - An entry retired in cycle N stops matching in cycle N+1.

## Structure
- The shared defines header holds `OITF_DEPTH` and a derived `OITF_PTR_W`. The existing `XLEN` and `RFIDX_WIDTH` remain the sources for those widths.
- One sub-module, `exu_oitf`: buffer, pointers, full/empty, dependency compare.
- `exu_wbck_arb` instantiates it and adds arbitration and the output register.

## Test plan
- **Reset, then single ALU write:** ALU valid with rdidx = 5, wdat = 0xDEADBEEF.
  - Expect `alu_wbck_i_ready` = 1.
  - Next cycle: `ena` = 1, rdidx = 5, wdat = 0xDEADBEEF.
- **Load round-trip:** dispatch a load with rd = 7.
  - Next cycle: `oitf_dep` = 1 for rs1 = 7; `oitf_empty` = 0.
  - LSU response wdat = 0x1234: next cycle a write to x7 with 0x1234; `oitf_empty` = 1.
- **Collision:** ALU (rd = 3) and LSU (head rd = 9) valid in the same cycle.
  - LSU is granted; `alu_wbck_i_ready` = 0.
  - The next cycle writes x9; the ALU write to x3 follows one cycle later.
- **Full OITF:** two loads dispatched (rd = 1, 2).
  - `ld_disp_ready` = 0.
  - A third dispatch is held even in a cycle where the first response retires.
  - Responses write x1 then x2 in order.
- **x0 and protocol violation:**
  - A load with rd = 0 retires with `ena` = 0 and `oitf_dep` never asserted for index 0.
  - LSU valid while empty: ready = 0, no write.
- **Reset mid-operation:** assert `rst` with two loads outstanding.
  - `oitf_empty` = 1 and `ena` = 0 afterward.
  - A subsequent stale LSU valid is refused.
